hl_mac_feeder: RTL and testbench
================================

Name: hl_mac_feeder

Overview:
Sequencer that drives the weight-write/calc side of the 56-lane hidden-layer MAC array (the PE_hl_mac_x56 port set); it is the producer for that array's inputs. It streams NUM_W int8 weights from a synchronous weight memory into the array, holds a latched uint8 ifmap while asserting calc, waits for complete, then captures the int32 ofmap. The captured result goes out on a valid/ready port to the activation/next-layer logic.

Parameters:
NUM_W, 56, number of weights written per load (lane ids 0..NUM_W-1, NUM_W ≤ 64)
ADDR_W, 12, weight-memory address width
TIMEOUT, 15, max cycles in CALC waiting for mac_complete before abort

Ports:
clk  in  1  clock, all logic on rising edge
rst_n  in  1  synchronous active-low reset
start  in  1  request one operation; sampled only in IDLE
reuse_w  in  1  with start: skip LOAD, reuse weights already in array
ifmap_in  in  8  uint8 input pixel, latched on accepted start
wbase  in  ADDR_W  weight-memory base address, latched on accepted start
busy  out  1  high in any state except IDLE
wmem_addr  out  ADDR_W  weight-memory read address
wmem_rd  out  1  weight-memory read enable
wmem_rdata  in  8  read data, valid exactly 1 cycle after wmem_rd
mac_write_weight  out  1  array weight-write strobe
mac_weight_id  out  6  array lane index
mac_weight  out  8  int8 weight to array
mac_calc  out  1  array calc enable (low = array clears)
mac_ifmap  out  8  ifmap to array
mac_ofmap  in  32  array result
mac_complete  in  1  array result valid
res_valid  out  1  result valid
res_ready  in  1  downstream accepts
res_data  out  32  captured int32 result
err  out  1  one-cycle pulse on CALC timeout

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; busy, wmem_rd, mac_write_weight, mac_calc, res_valid, err = 0; wmem_addr, mac_weight_id, mac_weight, mac_ifmap, res_data = 0. Reset mid-operation aborts immediately; mac_calc low next cycle clears the array.
- States: IDLE, LOAD, CALC, OUT.
- IDLE: start=1 -> latch ifmap_in, wbase; reuse_w=1 -> CALC, else -> LOAD with read counter k=0.
- LOAD: cycle k (0..NUM_W-1): wmem_rd=1, wmem_addr=wbase+k (mod 2^ADDR_W). Cycle k+1: mac_write_weight=1, mac_weight_id=k, mac_weight=wmem_rdata. Reads and writes overlap; LOAD lasts NUM_W+1 cycles. The last write occurs on the transition cycle into CALC. mac_calc=0 throughout.
- CALC: mac_calc=1, mac_ifmap=latched ifmap; mac_write_weight=0 always (the array gives write priority over calc). Cycle counter starts at 0. On mac_complete=1: res_data<=mac_ofmap, res_valid<=1, -> OUT. If counter reaches TIMEOUT with no complete: err pulse 1 cycle, -> IDLE, no result.
- OUT: mac_calc=0 (array clears, guaranteeing ≥1 low cycle between ops). res_valid held and res_data stable until res_ready=1. Transfer -> IDLE, with res_valid=0 the following cycle. A start during OUT is ignored; it is not queued.
- mac_ofmap treated as two's-complement int32 and passed unmodified. No saturation.
- After a reset, reuse_w=1 is legal, but array contents are undefined (array has no reset). That is the caller's responsibility.
- Latency start->res_valid: LOAD path NUM_W+1 + array latency (4) + 1 capture; reuse path 4+1.

Decomposition:
- Shared package hl_pkg: NUM_HL_LANES=56, lane-id width 6, ifmap/weight width 8, acc width 32, state encoding for this FSM.
- Single module; no sub-module. The LOAD address/id counter is inline.

Test Plan:
- Load+calc: weights mem[wbase+i]=i-28 (i=0..55), ifmap=3, array model sums lanes -> 56 writes with id 0..55 and weights -28..27, in order, one per cycle; res_data=3*(-28)=0xFFFFFFAC; res_valid 62 cycles after start.
- Reuse: second start with reuse_w=1, ifmap=10 -> no wmem_rd, no write strobes; res_data=-280; res_valid 5 cycles after start.
- Backpressure: hold res_ready=0 for 20 cycles -> res_valid and res_data stable, mac_calc=0, start ignored; res_ready=1 -> IDLE next cycle.
- Timeout: array model never asserts complete -> err pulses once at CALC cycle 15; busy=0 next cycle; no res_valid.
- Reset mid-LOAD: rst_n=0 at id 20 -> all outputs 0 next cycle; new start reloads from id 0.
- Address wrap: wbase=0xFF0 -> addresses 0xFF0..0xFFF, then 0x000..0x027; ids 0..55 still contiguous.

Source files
------------

// File: rtl/hl_pkg.sv
// Shared definitions for the hidden-layer MAC array and its feeder.
package hl_pkg;

  localparam int unsigned NUM_HL_LANES = 56;
  localparam int unsigned LANE_ID_W    = 6;
  localparam int unsigned DATA_W       = 8;
  localparam int unsigned ACC_W        = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_CALC = 2'd2,
    ST_OUT  = 2'd3
  } hl_state_e;

endpackage

// File: rtl/hl_mac_feeder.sv
// Sequencer feeding weights, ifmap and calc to the 56-lane MAC array and
// returning its int32 result over a valid/ready port.
module hl_mac_feeder
  import hl_pkg::*;
#(
  parameter int unsigned NUM_W   = NUM_HL_LANES,
  parameter int unsigned ADDR_W  = 12,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic                 reuse_w,
  input  logic [DATA_W-1:0]    ifmap_in,
  input  logic [ADDR_W-1:0]    wbase,
  output logic                 busy,
  output logic [ADDR_W-1:0]    wmem_addr,
  output logic                 wmem_rd,
  input  logic [DATA_W-1:0]    wmem_rdata,
  output logic                 mac_write_weight,
  output logic [LANE_ID_W-1:0] mac_weight_id,
  output logic [DATA_W-1:0]    mac_weight,
  output logic                 mac_calc,
  output logic [DATA_W-1:0]    mac_ifmap,
  input  logic [ACC_W-1:0]     mac_ofmap,
  input  logic                 mac_complete,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [ACC_W-1:0]     res_data,
  output logic                 err
);

  localparam int unsigned CNT_MAX = (NUM_W > TIMEOUT) ? NUM_W : TIMEOUT;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

  hl_state_e state, state_nx;

  logic [CNT_W-1:0]     cnt, cnt_nx;
  logic                 busy_nx;
  logic [ADDR_W-1:0]    wmem_addr_nx;
  logic                 wmem_rd_nx;
  logic                 wr_nx;
  logic [LANE_ID_W-1:0] id_nx;
  logic                 calc_nx;
  logic [DATA_W-1:0]    ifmap_nx;
  logic                 res_valid_nx;
  logic [ACC_W-1:0]     res_data_nx;
  logic                 err_nx;
  logic                 calc_done;

  // A complete arriving once the timeout counter has expired is ignored.
  assign calc_done = mac_complete && (cnt < CNT_W'(TIMEOUT));

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nx;
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (start) state_nx = reuse_w ? ST_CALC : ST_LOAD;
      ST_LOAD: if (cnt == CNT_W'(NUM_W)) state_nx = ST_CALC;
      ST_CALC: begin
        if (calc_done)                    state_nx = ST_OUT;
        else if (cnt >= CNT_W'(TIMEOUT))  state_nx = ST_IDLE;
      end
      ST_OUT:  if (res_ready) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and counters.
  always_comb begin
    cnt_nx       = cnt;
    busy_nx      = (state_nx != ST_IDLE);
    wmem_addr_nx = wmem_addr;
    wmem_rd_nx   = 1'b0;
    wr_nx        = 1'b0;
    id_nx        = mac_weight_id;
    calc_nx      = (state_nx == ST_CALC);
    ifmap_nx     = mac_ifmap;
    res_valid_nx = res_valid;
    res_data_nx  = res_data;
    err_nx       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          ifmap_nx = ifmap_in;
          cnt_nx   = '0;
          if (!reuse_w) begin
            wmem_rd_nx   = 1'b1;
            wmem_addr_nx = wbase;
          end
        end
      end
      // Read k and write k-1 overlap; the write trails the read by one cycle.
      ST_LOAD: begin
        if (cnt == CNT_W'(NUM_W)) begin
          cnt_nx = '0;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          wr_nx  = 1'b1;
          id_nx  = LANE_ID_W'(cnt);
          if (cnt != CNT_W'(NUM_W - 1)) begin
            wmem_rd_nx   = 1'b1;
            wmem_addr_nx = wmem_addr + ADDR_W'(1);
          end
        end
      end
      ST_CALC: begin
        if (calc_done) begin
          res_data_nx  = mac_ofmap;
          res_valid_nx = 1'b1;
        end else begin
          cnt_nx = cnt + CNT_W'(1);
          if (cnt == CNT_W'(TIMEOUT - 1)) err_nx = 1'b1;
        end
      end
      ST_OUT: if (res_ready) res_valid_nx = 1'b0;
      default: ;
    endcase
  end

  // Output and counter registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt              <= '0;
      busy             <= 1'b0;
      wmem_addr        <= '0;
      wmem_rd          <= 1'b0;
      mac_write_weight <= 1'b0;
      mac_weight_id    <= '0;
      mac_calc         <= 1'b0;
      mac_ifmap        <= '0;
      res_valid        <= 1'b0;
      res_data         <= '0;
      err              <= 1'b0;
    end else begin
      cnt              <= cnt_nx;
      busy             <= busy_nx;
      wmem_addr        <= wmem_addr_nx;
      wmem_rd          <= wmem_rd_nx;
      mac_write_weight <= wr_nx;
      mac_weight_id    <= id_nx;
      mac_calc         <= calc_nx;
      mac_ifmap        <= ifmap_nx;
      res_valid        <= res_valid_nx;
      res_data         <= res_data_nx;
      err              <= err_nx;
    end
  end

  // Memory data arrives one cycle after the read, so it passes straight through.
  assign mac_weight = mac_write_weight ? wmem_rdata : '0;

endmodule

// File: tb/tb_hl_mac_feeder.sv
// Directed bench for hl_mac_feeder with weight-memory and MAC-array models.
module tb_hl_mac_feeder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        reuse_w = 1'b0;
  logic [7:0]  ifmap_in = '0;
  logic [11:0] wbase = '0;
  logic        busy;
  logic [11:0] wmem_addr;
  logic        wmem_rd;
  logic [7:0]  wmem_rdata = '0;
  logic        mac_write_weight;
  logic [5:0]  mac_weight_id;
  logic [7:0]  mac_weight;
  logic        mac_calc;
  logic [7:0]  mac_ifmap;
  logic [31:0] mac_ofmap;
  logic        mac_complete;
  logic        res_valid;
  logic        res_ready = 1'b0;
  logic [31:0] res_data;
  logic        err;

  int errors = 0;
  int checks = 0;

  hl_mac_feeder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .reuse_w(reuse_w),
    .ifmap_in(ifmap_in), .wbase(wbase), .busy(busy),
    .wmem_addr(wmem_addr), .wmem_rd(wmem_rd), .wmem_rdata(wmem_rdata),
    .mac_write_weight(mac_write_weight), .mac_weight_id(mac_weight_id),
    .mac_weight(mac_weight), .mac_calc(mac_calc), .mac_ifmap(mac_ifmap),
    .mac_ofmap(mac_ofmap), .mac_complete(mac_complete),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .err(err)
  );

  always #5 clk = ~clk;

  // Synchronous weight memory.
  logic [7:0] wmem [0:4095];
  always @(posedge clk) if (wmem_rd) wmem_rdata <= wmem[wmem_addr];

  // Array model: completes on the 5th consecutive calc cycle, sums lane*ifmap.
  logic signed [7:0] arr_w [0:63] = '{default: 8'sd0};
  int calc_cnt = 0;
  bit en_complete = 1'b1;
  int acc;
  always @(posedge clk) begin
    if (mac_write_weight) arr_w[mac_weight_id] <= mac_weight;
    if (mac_calc) calc_cnt <= calc_cnt + 1;
    else          calc_cnt <= 0;
  end
  assign mac_complete = en_complete && mac_calc && (calc_cnt == 4);
  always_comb begin
    acc = 0;
    for (int i = 0; i < 56; i++) acc += int'(arr_w[i]) * int'(mac_ifmap);
    mac_ofmap = 32'(acc);
  end

  // Stream monitor: write ordering/values and read addresses.
  int wr_cnt = 0, wr_bad = 0, rd_cnt = 0, addr_bad = 0;
  logic [11:0] addr_exp_base = '0;
  logic [11:0] last_addr = '0;
  bit mon_clr = 1'b0;
  always @(posedge clk) begin
    if (mon_clr) begin
      wr_cnt <= 0; wr_bad <= 0; rd_cnt <= 0; addr_bad <= 0;
    end else begin
      if (mac_write_weight) begin
        if (int'(mac_weight_id) != wr_cnt || mac_weight !== 8'(int'(mac_weight_id) - 28))
          wr_bad <= wr_bad + 1;
        wr_cnt <= wr_cnt + 1;
      end
      if (wmem_rd) begin
        if (wmem_addr !== 12'(int'(addr_exp_base) + rd_cnt)) addr_bad <= addr_bad + 1;
        rd_cnt    <= rd_cnt + 1;
        last_addr <= wmem_addr;
      end
    end
  end

  task automatic fill(input logic [11:0] base);
    for (int i = 0; i < 56; i++) wmem[12'(int'(base) + i)] = 8'(i - 28);
    addr_exp_base = base;
  endtask

  task automatic clear_mon();
    @(negedge clk); mon_clr = 1'b1;
    @(posedge clk); #1; mon_clr = 1'b0;
  endtask

  task automatic do_start(input bit ru, input logic [7:0] px, input logic [11:0] wb);
    @(negedge clk);
    start = 1'b1; reuse_w = ru; ifmap_in = px; wbase = wb;
    @(posedge clk); #1;
    start = 1'b0; reuse_w = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      @(posedge clk); #1;
      if (res_valid) begin n = i; break; end
    end
  endtask

  task automatic handshake();
    @(negedge clk); res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, wmem_rd, mac_write_weight, mac_calc, res_valid, err} !== 6'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %b want 000000",
               {busy, wmem_rd, mac_write_weight, mac_calc, res_valid, err});
    end
    checks++;
    if ({wmem_addr, mac_weight_id, mac_weight, mac_ifmap, res_data} !== '0) begin
      errors++;
      $display("FAIL reset_data: addr=%h id=%h w=%h if=%h res=%h want all 0",
               wmem_addr, mac_weight_id, mac_weight, mac_ifmap, res_data);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_load_calc();
    int n;
    fill(12'h100);
    clear_mon();
    do_start(1'b0, 8'd3, 12'h100);
    wait_valid(n);
    checks++; if (n !== 62) begin errors++; $display("FAIL load_latency: got %0d want 62", n); end
    checks++; if (res_data !== 32'hFFFFFFAC) begin errors++; $display("FAIL load_result: got %h want FFFFFFAC", res_data); end
    checks++; if (wr_cnt !== 56) begin errors++; $display("FAIL load_wr_count: got %0d want 56", wr_cnt); end
    checks++; if (wr_bad !== 0) begin errors++; $display("FAIL load_wr_order: got %0d bad writes want 0", wr_bad); end
    checks++; if (rd_cnt !== 56) begin errors++; $display("FAIL load_rd_count: got %0d want 56", rd_cnt); end
    checks++; if (addr_bad !== 0) begin errors++; $display("FAIL load_addr: got %0d bad addrs want 0", addr_bad); end
    checks++; if ({busy, mac_calc} !== 2'b10) begin errors++; $display("FAIL out_state: busy,calc=%b want 10", {busy, mac_calc}); end
    handshake();
    checks++; if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL load_release: busy,valid=%b want 00", {busy, res_valid}); end
  endtask

  task automatic test_reuse();
    int n;
    clear_mon();
    do_start(1'b1, 8'd10, 12'h000);
    wait_valid(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL reuse_latency: got %0d want 5", n); end
    checks++; if (res_data !== 32'hFFFFFEE8) begin errors++; $display("FAIL reuse_result: got %h want FFFFFEE8", res_data); end
    checks++; if ({wr_cnt, rd_cnt} !== 64'd0) begin errors++; $display("FAIL reuse_no_load: wr=%0d rd=%0d want 0 0", wr_cnt, rd_cnt); end
    handshake();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reuse_release: busy=%b want 0", busy); end
  endtask

  task automatic test_backpressure();
    int n;
    do_start(1'b1, 8'd3, 12'h000);
    wait_valid(n);
    checks++; if (n !== 5) begin errors++; $display("FAIL bp_latency: got %0d want 5", n); end
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); start = 1'b1;
      checks++;
      if (res_valid !== 1'b1 || res_data !== 32'hFFFFFFAC || mac_calc !== 1'b0 || busy !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: valid=%b data=%h calc=%b busy=%b want 1 FFFFFFAC 0 1",
                 i, res_valid, res_data, mac_calc, busy);
      end
    end
    @(negedge clk); start = 1'b0; res_ready = 1'b1;
    @(posedge clk); #1; res_ready = 1'b0;
    checks++; if ({busy, res_valid} !== 2'b00) begin errors++; $display("FAIL bp_release: busy,valid=%b want 00", {busy, res_valid}); end
    repeat (2) @(posedge clk);
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL bp_not_queued: busy=%b want 0", busy); end
  endtask

  task automatic test_timeout();
    int err_cnt = 0, err_at = 0;
    bit busy_after = 1'b1, val_seen = 1'b0;
    en_complete = 1'b0;
    do_start(1'b1, 8'd5, 12'h000);
    for (int i = 1; i <= 30; i++) begin
      @(posedge clk); #1;
      if (err_at != 0 && i == err_at + 1) busy_after = busy;
      if (err) begin err_cnt++; err_at = i; end
      if (res_valid) val_seen = 1'b1;
    end
    en_complete = 1'b1;
    checks++; if (err_cnt !== 1) begin errors++; $display("FAIL to_err_count: got %0d want 1", err_cnt); end
    checks++; if (err_at !== 15) begin errors++; $display("FAIL to_err_cycle: got %0d want 15", err_at); end
    checks++; if (busy_after !== 1'b0) begin errors++; $display("FAIL to_busy_after: got %b want 0", busy_after); end
    checks++; if (val_seen !== 1'b0) begin errors++; $display("FAIL to_no_result: got %b want 0", val_seen); end
  endtask

  task automatic test_reset_mid_load();
    int n;
    bit hit = 1'b0;
    fill(12'h100);
    clear_mon();
    do_start(1'b0, 8'd3, 12'h100);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (mac_write_weight && mac_weight_id == 6'd20) begin hit = 1'b1; break; end
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL rst_reach_id20: got %b want 1", hit); end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({busy, wmem_rd, mac_write_weight, mac_calc, res_valid, err} !== 6'b0 ||
        {wmem_addr, mac_weight_id, mac_weight, mac_ifmap, res_data} !== '0) begin
      errors++;
      $display("FAIL rst_mid_load: ctrl=%b addr=%h id=%h w=%h if=%h want all 0",
               {busy, wmem_rd, mac_write_weight, mac_calc, res_valid, err},
               wmem_addr, mac_weight_id, mac_weight, mac_ifmap);
    end
    @(negedge clk); rst_n = 1'b1;
    clear_mon();
    do_start(1'b0, 8'd3, 12'h100);
    wait_valid(n);
    checks++; if (n !== 62) begin errors++; $display("FAIL rst_reload_latency: got %0d want 62", n); end
    checks++; if (res_data !== 32'hFFFFFFAC) begin errors++; $display("FAIL rst_reload_result: got %h want FFFFFFAC", res_data); end
    checks++; if (wr_cnt !== 56 || wr_bad !== 0) begin errors++; $display("FAIL rst_reload_writes: cnt=%0d bad=%0d want 56 0", wr_cnt, wr_bad); end
    handshake();
  endtask

  task automatic test_addr_wrap();
    int n;
    fill(12'hFF0);
    clear_mon();
    do_start(1'b0, 8'd7, 12'hFF0);
    wait_valid(n);
    checks++; if (n !== 62) begin errors++; $display("FAIL wrap_latency: got %0d want 62", n); end
    checks++; if (res_data !== 32'hFFFFFF3C) begin errors++; $display("FAIL wrap_result: got %h want FFFFFF3C", res_data); end
    checks++; if (rd_cnt !== 56 || addr_bad !== 0) begin errors++; $display("FAIL wrap_addrs: rd=%0d bad=%0d want 56 0", rd_cnt, addr_bad); end
    checks++; if (last_addr !== 12'h027) begin errors++; $display("FAIL wrap_last_addr: got %h want 027", last_addr); end
    checks++; if (wr_cnt !== 56 || wr_bad !== 0) begin errors++; $display("FAIL wrap_ids: cnt=%0d bad=%0d want 56 0", wr_cnt, wr_bad); end
    handshake();
  endtask

  initial begin
    test_reset();
    test_load_calc();
    test_reuse();
    test_backpressure();
    test_timeout();
    test_reset_mid_load();
    test_addr_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
